// File: rtl/hacd_pkg.sv
// Shared HAWK metadata-read types: AR payload struct, requester ids and arbiter state encoding.
package hacd_pkg;

   localparam int unsigned HACD_AXI4_ADDR_WIDTH = 64;
   localparam int unsigned HACD_AXI4_DATA_WIDTH = 512;

   localparam int unsigned HAWK_RD_REQ_PGRD   = 0;
   localparam int unsigned HAWK_RD_REQ_CMPRSN = 1;

   typedef struct packed {
      logic [HACD_AXI4_ADDR_WIDTH-1:0] addr;
      logic [7:0]                      arlen;
   } axi_rd_pld_t;

   typedef enum logic {
      ARB_ST  = 1'b0,
      HOLD_ST = 1'b1
   } arb_state_e;

endpackage

// File: rtl/hawk_owner_fifo.sv
// Owner FIFO recording which requester owns each in-flight read burst, in AR issue order.
module hawk_owner_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign full     = (cnt_q == CNT_W'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign count    = cnt_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign push_ok  = push & ~full;
   assign pop_ok   = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/hawk_axird_arb.sv
// Round-robin arbiter sharing the HAWK metadata AXI4 read channel; R beats are routed in order
// to the requester recorded at the head of the owner FIFO.
module hawk_axird_arb
   import hacd_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned MAX_OUTSTD = 4,
   parameter int unsigned ADDR_W     = HACD_AXI4_ADDR_WIDTH,
   parameter int unsigned DATA_W     = HACD_AXI4_DATA_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             s_arvalid,
   output logic [NUM_REQ-1:0]             s_arready,
   input  logic [NUM_REQ*ADDR_W-1:0]      s_araddr,
   input  logic [NUM_REQ*8-1:0]           s_arlen,
   output logic [NUM_REQ-1:0]             s_rvalid,
   input  logic [NUM_REQ-1:0]             s_rready,
   output logic [DATA_W-1:0]              s_rdata,
   output logic [1:0]                     s_rresp,
   output logic                           s_rlast,
   output logic                           m_arvalid,
   input  logic                           m_arready,
   output logic [ADDR_W-1:0]              m_araddr,
   output logic [7:0]                     m_arlen,
   input  logic                           m_rvalid,
   output logic                           m_rready,
   input  logic [DATA_W-1:0]              m_rdata,
   input  logic [1:0]                     m_rresp,
   input  logic                           m_rlast,
   output logic [$clog2(MAX_OUTSTD):0]    outstd_cnt,
   output logic                           err_unexp_r
);
   localparam int unsigned ID_W = $clog2(NUM_REQ);

   arb_state_e       state_q, state_d;
   logic [ID_W-1:0]  grant_q, grant_d;
   logic [ID_W-1:0]  rr_q, rr_d;
   logic             err_q, err_d;
   logic [ID_W-1:0]  pick_id, cand, ar_id, head_id;
   logic             pick_vld, ar_hs, r_pop, fifo_full, fifo_empty;
   axi_rd_pld_t      pld [NUM_REQ];

   always_comb begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         pld[i].addr  = HACD_AXI4_ADDR_WIDTH'(s_araddr[i*ADDR_W +: ADDR_W]);
         pld[i].arlen = s_arlen[i*8 +: 8];
      end
   end

   // First valid requester at or after the rr pointer; descending scan so the nearest wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_id  = rr_q;
      cand     = rr_q;
      for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
         cand = ID_W'((32'(rr_q) + 32'(k)) % NUM_REQ);
         if (s_arvalid[cand]) begin
            pick_vld = 1'b1;
            pick_id  = cand;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARB_ST;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      case (state_q)
         ARB_ST: begin
            if (m_arvalid && !m_arready) begin
               state_d = HOLD_ST;
               grant_d = pick_id;
            end
         end
         HOLD_ST: begin
            if (m_arready) state_d = ARB_ST;
         end
         default: state_d = ARB_ST;
      endcase
   end

   // FSM outputs: AR is presented the same cycle the grant is chosen
   always_comb begin
      m_arvalid = 1'b0;
      ar_id     = pick_id;
      case (state_q)
         ARB_ST:  m_arvalid = pick_vld & ~fifo_full;
         HOLD_ST: begin
            m_arvalid = 1'b1;
            ar_id     = grant_q;
         end
         default: m_arvalid = 1'b0;
      endcase
      ar_hs     = m_arvalid & m_arready;
      s_arready = '0;
      if (ar_hs) s_arready[ar_id] = 1'b1;
      m_araddr  = ADDR_W'(pld[ar_id].addr);
      m_arlen   = pld[ar_id].arlen;
   end

   always_comb begin
      rr_d = rr_q;
      if (ar_hs) rr_d = (32'(ar_id) == NUM_REQ - 1) ? '0 : ar_id + ID_W'(1);
   end

   // R routing; beats with no owner are drained and flagged
   always_comb begin
      s_rvalid = '0;
      m_rready = 1'b0;
      if (fifo_empty) begin
         m_rready = m_rvalid;
      end else begin
         s_rvalid[head_id] = m_rvalid;
         m_rready          = s_rready[head_id];
      end
      r_pop = m_rvalid & m_rready & m_rlast & ~fifo_empty;
      err_d = err_q | (m_rvalid & fifo_empty);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q  <= '0;
         err_q <= 1'b0;
      end else begin
         rr_q  <= rr_d;
         err_q <= err_d;
      end
   end

   assign s_rdata     = m_rdata;
   assign s_rresp     = m_rresp;
   assign s_rlast     = m_rlast;
   assign err_unexp_r = err_q;

   hawk_owner_fifo #(
      .DEPTH (MAX_OUTSTD),
      .WIDTH (ID_W)
   ) u_owner_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (ar_hs),
      .push_data (ar_id),
      .pop       (r_pop),
      .pop_data  (head_id),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (outstd_cnt)
   );

endmodule

// File: tb/tb_hawk_axird_arb.sv
// Bench for hawk_axird_arb: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_hawk_axird_arb;
   localparam int unsigned NUM_REQ    = 2;
   localparam int unsigned MAX_OUTSTD = 4;
   localparam int unsigned ADDR_W     = 64;
   localparam int unsigned DATA_W     = 512;

   logic                        clk = 1'b0;
   logic                        rst = 1'b1;
   logic [NUM_REQ-1:0]          s_arvalid = '0;
   logic [NUM_REQ-1:0]          s_arready;
   logic [NUM_REQ*ADDR_W-1:0]   s_araddr = '0;
   logic [NUM_REQ*8-1:0]        s_arlen = '0;
   logic [NUM_REQ-1:0]          s_rvalid;
   logic [NUM_REQ-1:0]          s_rready = '0;
   logic [DATA_W-1:0]           s_rdata;
   logic [1:0]                  s_rresp;
   logic                        s_rlast;
   logic                        m_arvalid;
   logic                        m_arready = 1'b0;
   logic [ADDR_W-1:0]           m_araddr;
   logic [7:0]                  m_arlen;
   logic                        m_rvalid = 1'b0;
   logic                        m_rready;
   logic [DATA_W-1:0]           m_rdata = '0;
   logic [1:0]                  m_rresp = '0;
   logic                        m_rlast = 1'b0;
   logic [$clog2(MAX_OUTSTD):0] outstd_cnt;
   logic                        err_unexp_r;

   always #5 clk = ~clk;

   hawk_axird_arb #(
      .NUM_REQ    (NUM_REQ),
      .MAX_OUTSTD (MAX_OUTSTD),
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .s_arvalid   (s_arvalid),
      .s_arready   (s_arready),
      .s_araddr    (s_araddr),
      .s_arlen     (s_arlen),
      .s_rvalid    (s_rvalid),
      .s_rready    (s_rready),
      .s_rdata     (s_rdata),
      .s_rresp     (s_rresp),
      .s_rlast     (s_rlast),
      .m_arvalid   (m_arvalid),
      .m_arready   (m_arready),
      .m_araddr    (m_araddr),
      .m_arlen     (m_arlen),
      .m_rvalid    (m_rvalid),
      .m_rready    (m_rready),
      .m_rdata     (m_rdata),
      .m_rresp     (m_rresp),
      .m_rlast     (m_rlast),
      .outstd_cnt  (outstd_cnt),
      .err_unexp_r (err_unexp_r)
   );

   int n_chk = 0;
   int n_err = 0;

   // requester-side stimulus state
   bit                 pend   [NUM_REQ];
   logic [ADDR_W-1:0]  a_addr [NUM_REQ];
   logic [7:0]         a_len  [NUM_REQ];

   // reference model: bursts in flight as (owner, length) in issue order
   int  q_id  [$];
   int  q_len [$];
   bit  md_hold;
   int  md_held;
   int  md_rr;
   bit  md_err;
   int  beat_cnt;

   task automatic chk(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic apply();
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         s_arvalid[i]                = pend[i];
         s_araddr[i*ADDR_W +: ADDR_W] = a_addr[i];
         s_arlen[i*8 +: 8]           = a_len[i];
      end
   endtask

   task automatic model_reset();
      q_id.delete();
      q_len.delete();
      md_hold  = 1'b0;
      md_held  = 0;
      md_rr    = 0;
      md_err   = 1'b0;
      beat_cnt = 0;
   endtask

   // Check all outputs against the model for the current inputs, then advance one clock.
   task automatic step();
      bit arv, hs, exp_rrdy, mrv, mlast, empty;
      int id;
      logic [NUM_REQ-1:0] exp_arrdy, exp_rv;
      #1;
      arv = 1'b0;
      id  = 0;
      if (md_hold) begin
         arv = 1'b1;
         id  = md_held;
      end else if (q_id.size() < int'(MAX_OUTSTD)) begin
         for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            int j = (md_rr + k) % int'(NUM_REQ);
            if (s_arvalid[j]) begin
               arv = 1'b1;
               id  = j;
            end
         end
      end
      chk("m_arvalid", DATA_W'(m_arvalid), DATA_W'(arv));
      if (arv) begin
         chk("m_araddr", DATA_W'(m_araddr), DATA_W'(a_addr[id]));
         chk("m_arlen", DATA_W'(m_arlen), DATA_W'(a_len[id]));
      end
      hs        = arv && m_arready;
      exp_arrdy = '0;
      if (hs) exp_arrdy[id] = 1'b1;
      chk("s_arready", DATA_W'(s_arready), DATA_W'(exp_arrdy));

      empty  = (q_id.size() == 0);
      exp_rv = '0;
      if (empty) begin
         exp_rrdy = m_rvalid;
      end else begin
         exp_rv[q_id[0]] = m_rvalid;
         exp_rrdy        = s_rready[q_id[0]];
      end
      chk("s_rvalid", DATA_W'(s_rvalid), DATA_W'(exp_rv));
      chk("m_rready", DATA_W'(m_rready), DATA_W'(exp_rrdy));
      chk("s_rdata", s_rdata, m_rdata);
      chk("s_rresp_rlast", DATA_W'({s_rresp, s_rlast}), DATA_W'({m_rresp, m_rlast}));
      chk("outstd_cnt", DATA_W'(outstd_cnt), DATA_W'(q_id.size()));
      chk("err_unexp_r", DATA_W'(err_unexp_r), DATA_W'(md_err));

      mrv   = m_rvalid;
      mlast = m_rlast;
      @(posedge clk);
      if (empty) begin
         if (mrv) md_err = 1'b1;
      end else if (mrv && exp_rrdy) begin
         if (mlast) begin
            void'(q_id.pop_front());
            void'(q_len.pop_front());
            beat_cnt = 0;
         end else begin
            beat_cnt++;
         end
      end
      if (hs) begin
         q_id.push_back(id);
         q_len.push_back(int'(a_len[id]));
         md_rr    = (id + 1) % int'(NUM_REQ);
         md_hold  = 1'b0;
         pend[id] = 1'b0;
      end else if (arv) begin
         md_hold = 1'b1;
         md_held = id;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      for (int i = 0; i < int'(NUM_REQ); i++) pend[i] = 1'b0;
      apply();
      m_rvalid  = 1'b0;
      m_rlast   = 1'b0;
      m_arready = 1'b0;
      s_rready  = '0;
      rst       = 1'b1;
      #1;
      chk("rst_m_arvalid", DATA_W'(m_arvalid), '0);
      chk("rst_s_arready", DATA_W'(s_arready), '0);
      chk("rst_s_rvalid", DATA_W'(s_rvalid), '0);
      chk("rst_m_rready", DATA_W'(m_rready), '0);
      chk("rst_outstd", DATA_W'(outstd_cnt), '0);
      chk("rst_err", DATA_W'(err_unexp_r), '0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic rand_drive();
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (!pend[i] && ($urandom % 4 == 0)) begin
            pend[i]   = 1'b1;
            a_addr[i] = {$urandom, $urandom};
            a_len[i]  = 8'($urandom % 4);
         end
      end
      apply();
      m_arready = ($urandom % 3) != 0;
      s_rready  = NUM_REQ'($urandom);
      if (q_id.size() != 0 && ($urandom % 2 == 1)) begin
         m_rvalid = 1'b1;
         m_rlast  = (beat_cnt == q_len[0]);
      end else begin
         m_rvalid = 1'b0;
         m_rlast  = 1'($urandom);
      end
      for (int w = 0; w < int'(DATA_W / 32); w++) m_rdata[w*32 +: 32] = $urandom;
      m_rresp = 2'($urandom);
   endtask

   initial begin
      logic [NUM_REQ-1:0] drain_exp [4];
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         pend[i]   = 1'b0;
         a_addr[i] = '0;
         a_len[i]  = '0;
      end
      model_reset();
      @(negedge clk);
      do_reset();

      // both requesters at once, rr at 0: req0 then req1
      pend[0] = 1'b1; a_addr[0] = 64'h0000_1000_0000_0040; a_len[0] = 8'd0;
      pend[1] = 1'b1; a_addr[1] = 64'h0000_2000_0000_0080; a_len[1] = 8'd0;
      m_arready = 1'b1;
      apply();
      #1 chk("t2_gnt0", DATA_W'(s_arready), DATA_W'(2'b01));
      step();
      apply();
      #1 chk("t2_gnt1", DATA_W'(s_arready), DATA_W'(2'b10));
      step();
      apply();
      #1 chk("t2_cnt", DATA_W'(outstd_cnt), DATA_W'(2));

      // AR stall: grant and address frozen on req0 while req1 waits
      m_arready = 1'b0;
      pend[0] = 1'b1; a_addr[0] = 64'hdead_beef_0000_0100;
      apply();
      for (int c = 0; c < 3; c++) begin
         if (c == 1) begin
            pend[1] = 1'b1; a_addr[1] = 64'hcafe_f00d_0000_0200;
            apply();
         end
         #1;
         chk("t3_addr_hold", DATA_W'(m_araddr), DATA_W'(64'hdead_beef_0000_0100));
         chk("t3_no_rdy", DATA_W'(s_arready), '0);
         step();
      end
      m_arready = 1'b1;
      #1 chk("t3_rel0", DATA_W'(s_arready), DATA_W'(2'b01));
      step();
      apply();
      #1 chk("t3_rel1", DATA_W'(s_arready), DATA_W'(2'b10));
      step();
      apply();

      // FIFO full: fifth AR blocked; a pop frees it only on the following cycle
      pend[0] = 1'b1; a_addr[0] = 64'h0000_0000_0000_0c00;
      apply();
      #1;
      chk("t4_cnt_full", DATA_W'(outstd_cnt), DATA_W'(4));
      chk("t4_blocked", DATA_W'(m_arvalid), '0);
      step();
      s_rready = 2'b11; m_rvalid = 1'b1; m_rlast = 1'b1;
      #1;
      chk("t4_pop_route", DATA_W'(s_rvalid), DATA_W'(2'b01));
      chk("t4_same_cyc_blk", DATA_W'(m_arvalid), '0);
      step();
      m_rvalid = 1'b0;
      #1;
      chk("t4_unblock", DATA_W'(s_arready), DATA_W'(2'b01));
      chk("t4_cnt3", DATA_W'(outstd_cnt), DATA_W'(3));
      step();
      apply();
      drain_exp[0] = 2'b10; drain_exp[1] = 2'b01; drain_exp[2] = 2'b10; drain_exp[3] = 2'b01;
      m_rvalid = 1'b1; m_rlast = 1'b1;
      for (int b = 0; b < 4; b++) begin
         #1 chk("t4_drain_route", DATA_W'(s_rvalid), DATA_W'(drain_exp[b]));
         step();
      end
      m_rvalid = 1'b0;

      // multi-beat burst to req0, single beat to req1, with a requester stall
      pend[0] = 1'b1; a_addr[0] = 64'h0000_0000_0001_0000; a_len[0] = 8'd3;
      apply();
      step();
      pend[1] = 1'b1; a_addr[1] = 64'h0000_0000_0002_0000; a_len[1] = 8'd0;
      apply();
      step();
      apply();
      m_rvalid = 1'b1; m_rlast = 1'b0; s_rready = 2'b10;
      #1;
      chk("t5_stall_rready", DATA_W'(m_rready), '0);
      chk("t5_stall_route", DATA_W'(s_rvalid), DATA_W'(2'b01));
      step();
      s_rready = 2'b11;
      for (int b = 0; b < 4; b++) begin
         m_rlast = (b == 3);
         #1 chk("t5_req0_beat", DATA_W'(s_rvalid), DATA_W'(2'b01));
         step();
      end
      m_rlast = 1'b1;
      #1 chk("t5_req1_beat", DATA_W'(s_rvalid), DATA_W'(2'b10));
      step();
      m_rvalid = 1'b0;
      step();

      // unexpected R beat with nothing outstanding
      do_reset();
      m_rvalid = 1'b1; m_rlast = 1'b1;
      #1;
      chk("t6_drain_rready", DATA_W'(m_rready), DATA_W'(1));
      chk("t6_no_rvalid", DATA_W'(s_rvalid), '0);
      step();
      m_rvalid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1 chk("t6_err_sticky", DATA_W'(err_unexp_r), DATA_W'(1));
         step();
      end

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rand_drive();
         step();
      end

      // reset mid-run
      do_reset();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
